// File: rtl/tt_sweep_capture.sv
// Sweeps every input vector of a combinational netlist, assembles the observed output into a
// truth-table word and compares it against a reference table latched at sweep start.
module tt_sweep_capture #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(2**N_IN)-1:0]   expected_tt,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(2**N_IN)-1:0]   tt_out,
    output logic                   match,
    output logic [(2**N_IN)-1:0]   mismatch_mask
);

    localparam int unsigned TW = 2 ** N_IN;
    localparam int unsigned SW = (SETTLE == 0) ? 1 : $clog2(SETTLE + 1);

    localparam logic [SW-1:0]   SettleMax = SW'(SETTLE);
    localparam logic [SW-1:0]   SettleOne = SW'(1);
    localparam logic [N_IN-1:0] IdxMax    = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IdxOne    = N_IN'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [TW-1:0]   tt_q, tt_d;
    logic [TW-1:0]   exp_q, exp_d;
    logic            match_q, match_d;
    logic [TW-1:0]   mask_q, mask_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        tt_d     = tt_q;
        exp_d    = exp_q;
        match_d  = match_q;
        mask_d   = mask_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StHold;
                    idx_d    = '0;
                    settle_d = '0;
                    tt_d     = '0;
                    exp_d    = expected_tt;
                    match_d  = 1'b0;
                    mask_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (settle_q != SettleMax) begin
                    settle_d = settle_q + SettleOne;
                end else begin
                    tt_d[idx_q] = dut_out;
                    if (idx_q == IdxMax) begin
                        // Compare against the table including the bit written at this edge.
                        state_d = StDone;
                        match_d = (tt_d == exp_q);
                        mask_d  = tt_d ^ exp_q;
                    end else begin
                        idx_d    = idx_q + IdxOne;
                        settle_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            settle_q <= '0;
            tt_q     <= '0;
            exp_q    <= '0;
            match_q  <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            tt_q     <= tt_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
            mask_q   <= mask_d;
        end
    end

    // idx only changes inside a sweep, so it also holds the last vector in DONE and IDLE.
    assign dut_in        = idx_q;
    assign busy          = (state_q == StHold);
    assign done          = (state_q == StDone);
    assign tt_out        = tt_q;
    assign match         = match_q;
    assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: a SETTLE=2 instance with a selectable zero/two-cycle-delay
// netlist model, and a SETTLE=0 instance driven by the delayed model.
module tb_tt_sweep_capture;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        start_a, start_b;
    logic [15:0] exp_a, exp_b;
    logic [3:0]  in_a, in_b;
    logic        out_a, out_b;
    logic        busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [15:0] tt_a, tt_b, mask_a, mask_b;

    logic [15:0] model_tt;
    logic        delay_a;
    logic [3:0]  a_d1, a_d2, b_d1, b_d2;

    int n_cmp  = 0;
    int n_fail = 0;

    tt_sweep_capture #(.N_IN(4), .SETTLE(2)) u_dut_a (
        .clk           (clk),
        .rst           (rst),
        .start         (start_a),
        .expected_tt   (exp_a),
        .dut_in        (in_a),
        .dut_out       (out_a),
        .busy          (busy_a),
        .done          (done_a),
        .tt_out        (tt_a),
        .match         (match_a),
        .mismatch_mask (mask_a)
    );

    tt_sweep_capture #(.N_IN(4), .SETTLE(0)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .start         (start_b),
        .expected_tt   (exp_b),
        .dut_in        (in_b),
        .dut_out       (out_b),
        .busy          (busy_b),
        .done          (done_b),
        .tt_out        (tt_b),
        .match         (match_b),
        .mismatch_mask (mask_b)
    );

    // Netlist models: output bit dut_in of model_tt, optionally seen two cycles late.
    always @(posedge clk) begin
        a_d1 <= in_a;
        a_d2 <= a_d1;
        b_d1 <= in_b;
        b_d2 <= b_d1;
    end
    assign out_a = delay_a ? model_tt[a_d2] : model_tt[in_a];
    assign out_b = model_tt[b_d2];

    // One sweep on instance A; cycle 1 is the cycle after the edge that samples start.
    task automatic sweep_a(input logic [15:0] expv, input bit inject,
                           output int done_cyc, output int done_cnt, output int busy_err);
        done_cyc = -1;
        done_cnt = 0;
        busy_err = 0;
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = expv;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (done_a === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy_a !== (c <= 48)) busy_err++;
            if (inject) begin
                start_a = (c == 10 || c == 30);
                if (c == 20) exp_a = ~expv;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if ({busy_a, done_a, match_a} !== 3'b000 || in_a !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/match=%b dut_in=%h want 000 / 0",
                     {busy_a, done_a, match_a}, in_a);
        end
        n_cmp++;
        if (tt_a !== 16'h0 || mask_a !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_tables: tt=%h mask=%h want 0000/0000", tt_a, mask_a);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || tt_a !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b tt=%h want 0/0/0000", busy_a, done_a, tt_a);
        end
    endtask

    task automatic test_basic;
        int dc, dn, be;
        delay_a  = 1'b0;
        model_tt = 16'h2A56;
        sweep_a(16'h2A56, 1'b0, dc, dn, be);
        n_cmp++;
        if (dc != 49 || dn != 1 || be != 0) begin
            n_fail++;
            $display("FAIL basic_timing: done_cyc=%0d cnt=%0d busy_err=%0d want 49/1/0", dc, dn, be);
        end
        n_cmp++;
        if (tt_a !== 16'h2A56 || match_a !== 1'b1 || mask_a !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_result: tt=%h match=%b mask=%h want 2a56/1/0000",
                     tt_a, match_a, mask_a);
        end
        sweep_a(16'h2A57, 1'b0, dc, dn, be);
        n_cmp++;
        if (tt_a !== 16'h2A56 || match_a !== 1'b0 || mask_a !== 16'h0001) begin
            n_fail++;
            $display("FAIL exp_off_by_one: tt=%h match=%b mask=%h want 2a56/0/0001",
                     tt_a, match_a, mask_a);
        end
    endtask

    task automatic test_random;
        int dc, dn, be;
        logic [15:0] expv;
        delay_a = 1'b0;
        for (int it = 0; it < 6; it++) begin
            model_tt = 16'($urandom);
            case (it % 3)
                0:       expv = model_tt;
                1:       expv = model_tt ^ (16'h1 << $urandom_range(15, 0));
                default: expv = 16'($urandom);
            endcase
            sweep_a(expv, 1'b0, dc, dn, be);
            n_cmp++;
            if (tt_a !== model_tt || mask_a !== (model_tt ^ expv)
                || match_a !== (model_tt == expv)) begin
                n_fail++;
                $display("FAIL random_%0d: tt=%h mask=%h match=%b want %h/%h/%b", it,
                         tt_a, mask_a, match_a, model_tt, model_tt ^ expv, model_tt == expv);
            end
            n_cmp++;
            if (dc != 49 || dn != 1 || be != 0) begin
                n_fail++;
                $display("FAIL random_timing_%0d: done_cyc=%0d cnt=%0d busy_err=%0d want 49/1/0",
                         it, dc, dn, be);
            end
        end
    endtask

    task automatic test_delay;
        int dc, dn, be;
        int bdone;
        model_tt = 16'h2A56;
        delay_a  = 1'b1;
        sweep_a(16'h2A56, 1'b0, dc, dn, be);
        n_cmp++;
        if (tt_a !== 16'h2A56 || dc != 49) begin
            n_fail++;
            $display("FAIL delay_settle2: tt=%h done_cyc=%0d want 2a56/49", tt_a, dc);
        end
        delay_a = 1'b0;
        bdone   = -1;
        @(negedge clk);
        start_b = 1'b1;
        exp_b   = 16'h2A56;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (done_b === 1'b1 && bdone < 0) bdone = c;
            @(negedge clk);
        end
        n_cmp++;
        if (bdone != 17) begin
            n_fail++;
            $display("FAIL delay_settle0_done: done_cyc=%0d want 17", bdone);
        end
        n_cmp++;
        if (tt_b === 16'h2A56) begin
            n_fail++;
            $display("FAIL delay_settle0_tt: tt=%h want anything but 2a56", tt_b);
        end
    endtask

    task automatic test_hold_rules;
        int dc, dn, be;
        delay_a  = 1'b0;
        model_tt = 16'h2A56;
        sweep_a(16'h2A56, 1'b1, dc, dn, be);
        n_cmp++;
        if (dc != 49 || dn != 1 || be != 0) begin
            n_fail++;
            $display("FAIL hold_timing: done_cyc=%0d cnt=%0d busy_err=%0d want 49/1/0", dc, dn, be);
        end
        n_cmp++;
        if (tt_a !== 16'h2A56 || match_a !== 1'b1 || mask_a !== 16'h0) begin
            n_fail++;
            $display("FAIL hold_result: tt=%h match=%b mask=%h want 2a56/1/0000",
                     tt_a, match_a, mask_a);
        end
        n_cmp++;
        if (in_a !== 4'hF) begin
            n_fail++;
            $display("FAIL hold_dut_in_idle: dut_in=%h want f", in_a);
        end
    endtask

    task automatic test_mid_reset;
        int dc, dn, be;
        int rdone;
        model_tt = 16'h2A56;
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = 16'h2A56;
        @(negedge clk);
        start_a = 1'b0;
        repeat (22) @(negedge clk);
        // Now in cycle 23, the middle of vector 7's window.
        n_cmp++;
        if (in_a !== 4'h7 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_before: dut_in=%h busy=%b want 7/1", in_a, busy_a);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (busy_a !== 1'b0 || tt_a !== 16'h0 || in_a !== 4'h0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_abort: busy=%b tt=%h dut_in=%h done=%b want 0/0000/0/0",
                     busy_a, tt_a, in_a, done_a);
        end
        rdone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a === 1'b1) rdone++;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done_a === 1'b1) rdone++;
        end
        n_cmp++;
        if (rdone != 0) begin
            n_fail++;
            $display("FAIL midrst_no_done: done pulses=%0d want 0", rdone);
        end
        sweep_a(16'h2A56, 1'b0, dc, dn, be);
        n_cmp++;
        if (tt_a !== 16'h2A56 || dc != 49 || match_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_restart: tt=%h done_cyc=%0d match=%b want 2a56/49/1",
                     tt_a, dc, match_a);
        end
    endtask

    task automatic test_back_to_back;
        int d1, d2, dn;
        logic [15:0] tt50;
        logic        busy50;
        model_tt = 16'h2A56;
        d1 = -1;
        d2 = -1;
        dn = 0;
        tt50   = 16'hFFFF;
        busy50 = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = 16'h2A56;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 1; c <= 120; c++) begin
            if (done_a === 1'b1) begin
                dn++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == 50) begin
                tt50   = tt_a;
                busy50 = busy_a;
            end
            if (c == 45) start_a = 1'b1;
            if (c == 50) start_a = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (d1 != 49 || dn != 2) begin
            n_fail++;
            $display("FAIL b2b_first: done_cyc=%0d cnt=%0d want 49/2", d1, dn);
        end
        // The second sweep is accepted at the done-cycle edge, so it completes 49 cycles later.
        n_cmp++;
        if (d2 - d1 != 49) begin
            n_fail++;
            $display("FAIL b2b_spacing: second-first=%0d want 49", d2 - d1);
        end
        n_cmp++;
        if (tt50 !== 16'h0 || busy50 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: tt=%h busy=%b at cycle 50 want 0000/1", tt50, busy50);
        end
        n_cmp++;
        if (tt_a !== 16'h2A56 || match_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_result: tt=%h match=%b want 2a56/1", tt_a, match_a);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        exp_a    = 16'h0;
        exp_b    = 16'h0;
        delay_a  = 1'b0;
        model_tt = 16'h0;
        test_reset();
        test_basic();
        test_random();
        test_delay();
        test_hold_rules();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
